// File: rtl/rs_simple.sv
// Two-entry reservation station for the simple integer FU: holds dispatched ops, wakes operands
// from the CDB by ROB tag, and frees entries on issue. RS_SIMPLE_PERF_EN adds perf counters.
module rs_simple #(
    parameter int unsigned ENTRY_W = 114,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               dispatch_valid,
    input  logic [ENTRY_W-1:0] dispatch_inst,
    input  logic [TAG_W-1:0]   dispatch_rob_num,
    output logic               dispatch_ready,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic [ENTRY_W-1:0] rs_simple_0,
    output logic [ENTRY_W-1:0] rs_simple_1,
    output logic [TAG_W-1:0]   rs_simple_0_entry_num,
    output logic [TAG_W-1:0]   rs_simple_1_entry_num,
    output logic               selector,
`ifdef RS_SIMPLE_PERF_EN
    output logic [31:0]        perf_issue_cnt,
    output logic [31:0]        perf_full_cnt,
`endif
    input  logic               simple_0_issue,
    input  logic               simple_1_issue
);

    localparam int unsigned S1_V   = 5;
    localparam int unsigned S1_LSB = S1_V + 1;
    localparam int unsigned S2_V   = S1_LSB + DATA_W;
    localparam int unsigned S2_LSB = S2_V + 1;

    logic [1:0]                busy_q, busy_d;
    logic [1:0][ENTRY_W-1:0]   payload_q, payload_d;
    logic [1:0][TAG_W-1:0]     rob_q, rob_d;
    logic                      sel_q, sel_d;
    logic [1:0]                issue;
    logic [1:0]                freed;
    logic                      ready;
    logic                      accept;
    logic                      target;

    // Replace any pending source whose tag matches a valid broadcast with the broadcast value.
    function automatic logic [ENTRY_W-1:0] wake(input logic [ENTRY_W-1:0] e,
                                                input logic               v,
                                                input logic [TAG_W-1:0]   tag,
                                                input logic [DATA_W-1:0]  data);
        logic [ENTRY_W-1:0] r;
        r = e;
        if (v) begin
            if (!e[S1_V] && (e[S1_LSB +: TAG_W] == tag)) begin
                r[S1_LSB +: DATA_W] = data;
                r[S1_V]             = 1'b1;
            end
            if (!e[S2_V] && (e[S2_LSB +: TAG_W] == tag)) begin
                r[S2_LSB +: DATA_W] = data;
                r[S2_V]             = 1'b1;
            end
        end
        return r;
    endfunction

    // Empty entries must never look ready to the FU.
    function automatic logic [ENTRY_W-1:0] present(input logic [ENTRY_W-1:0] e,
                                                   input logic               b);
        logic [ENTRY_W-1:0] r;
        r = e;
        if (!b) begin
            r[S1_V] = 1'b0;
            r[S2_V] = 1'b0;
        end
        return r;
    endfunction

    assign issue  = {simple_1_issue, simple_0_issue};
    assign freed  = issue & busy_q;
    assign ready  = ~(busy_q[0] & busy_q[1]);
    assign accept = dispatch_valid & ready;
    assign target = busy_q[0];

    always_comb begin
        busy_d    = busy_q;
        payload_d = payload_q;
        rob_d     = rob_q;
        sel_d     = sel_q;
        for (int i = 0; i < 2; i++) begin
            if (busy_q[i]) begin
                payload_d[i] = wake(payload_q[i], cdb_valid, cdb_tag, cdb_data);
            end
            if (freed[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        // Target comes from registered occupancy, so a slot freed this cycle is not reused.
        if (accept) begin
            busy_d[target]    = 1'b1;
            payload_d[target] = wake(dispatch_inst, cdb_valid, cdb_tag, cdb_data);
            rob_d[target]     = dispatch_rob_num;
            sel_d             = target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_q    <= '0;
            payload_q <= '0;
            rob_q     <= '0;
            sel_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            payload_q <= payload_d;
            rob_q     <= rob_d;
            sel_q     <= sel_d;
        end
    end

    always_comb begin
        dispatch_ready        = ready;
        rs_simple_0           = present(payload_q[0], busy_q[0]);
        rs_simple_1           = present(payload_q[1], busy_q[1]);
        rs_simple_0_entry_num = rob_q[0];
        rs_simple_1_entry_num = rob_q[1];
        selector              = sel_q;
    end

`ifdef RS_SIMPLE_PERF_EN
    logic [31:0] issue_cnt_q;
    logic [31:0] full_cnt_q;

    // Counters survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            if (!flush) begin
                issue_cnt_q <= issue_cnt_q + {31'b0, freed[0]} + {31'b0, freed[1]};
            end
            if (dispatch_valid && !ready) begin
                full_cnt_q <= full_cnt_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = issue_cnt_q;
    assign perf_full_cnt  = full_cnt_q;
`endif

endmodule

// File: tb/tb_rs_simple.sv
// Scoreboard bench for rs_simple: stimulus pushes expected post-edge state, a negedge monitor
// pops and compares. Define RS_SIMPLE_PERF_EN to also check the perf counters.
module tb_rs_simple;

    logic           clk = 1'b0;
    logic           rst, flush, dispatch_valid, cdb_valid;
    logic [113:0]   dispatch_inst;
    logic [3:0]     dispatch_rob_num, cdb_tag;
    logic [31:0]    cdb_data;
    logic           dispatch_ready, selector;
    logic [113:0]   rs_simple_0, rs_simple_1;
    logic [3:0]     rs_simple_0_entry_num, rs_simple_1_entry_num;
    logic           simple_0_issue, simple_1_issue;
    logic [31:0]    perf_issue_cnt, perf_full_cnt;

    rs_simple dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush                 (flush),
        .dispatch_valid        (dispatch_valid),
        .dispatch_inst         (dispatch_inst),
        .dispatch_rob_num      (dispatch_rob_num),
        .dispatch_ready        (dispatch_ready),
        .cdb_valid             (cdb_valid),
        .cdb_tag               (cdb_tag),
        .cdb_data              (cdb_data),
        .rs_simple_0           (rs_simple_0),
        .rs_simple_1           (rs_simple_1),
        .rs_simple_0_entry_num (rs_simple_0_entry_num),
        .rs_simple_1_entry_num (rs_simple_1_entry_num),
        .selector              (selector),
`ifdef RS_SIMPLE_PERF_EN
        .perf_issue_cnt        (perf_issue_cnt),
        .perf_full_cnt         (perf_full_cnt),
`endif
        .simple_0_issue        (simple_0_issue),
        .simple_1_issue        (simple_1_issue)
    );

`ifndef RS_SIMPLE_PERF_EN
    assign perf_issue_cnt = '0;
    assign perf_full_cnt  = '0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           cyc;
        logic [113:0] e0, e1;
        logic [3:0]   n0, n1;
        logic         sel, rdy;
        logic         perf;
        logic [31:0]  icnt, fcnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [113:0] mk(input logic [5:0] aluop, input logic [31:0] s2,
                                        input logic s2v, input logic [31:0] s1, input logic s1v,
                                        input logic [4:0] rd);
        return {32'h0, aluop, 4'h0, 1'b1, s2, s2v, s1, s1v, rd};
    endfunction

    function automatic logic [113:0] msk(input logic [113:0] e);
        logic [113:0] r;
        r     = e;
        r[38] = 1'b0;
        r[5]  = 1'b0;
        return r;
    endfunction

    // Expected state visible after the coming rising edge.
    task automatic expect_st(input string name, input logic [113:0] e0, input logic [113:0] e1,
                             input logic [3:0] n0, input logic [3:0] n1, input logic sel,
                             input logic rdy);
        exp_t x;
        x.name = name; x.cyc = cyc + 1;
        x.e0 = e0; x.e1 = e1; x.n0 = n0; x.n1 = n1; x.sel = sel; x.rdy = rdy;
        x.perf = 1'b0; x.icnt = '0; x.fcnt = '0;
        q.push_back(x);
    endtask

    task automatic expect_perf(input string name, input logic [31:0] icnt,
                               input logic [31:0] fcnt);
        exp_t x;
        x.name = name; x.cyc = cyc + 1;
        x.e0 = '0; x.e1 = '0; x.n0 = '0; x.n1 = '0; x.sel = 1'b0; x.rdy = 1'b0;
        x.perf = 1'b1; x.icnt = icnt; x.fcnt = fcnt;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc == cyc) begin
                x = q.pop_front();
                checks++;
                if (x.perf) begin
                    if (perf_issue_cnt !== x.icnt || perf_full_cnt !== x.fcnt) begin
                        errors++;
                        $display("FAIL %s: issue_cnt=%0d full_cnt=%0d, required %0d %0d",
                                 x.name, perf_issue_cnt, perf_full_cnt, x.icnt, x.fcnt);
                    end
                end else if (rs_simple_0 !== x.e0 || rs_simple_1 !== x.e1 ||
                             rs_simple_0_entry_num !== x.n0 || rs_simple_1_entry_num !== x.n1 ||
                             selector !== x.sel || dispatch_ready !== x.rdy) begin
                    errors++;
                    $display("FAIL %s: e0=%h e1=%h n0=%h n1=%h sel=%b rdy=%b, required e0=%h e1=%h n0=%h n1=%h sel=%b rdy=%b",
                             x.name, rs_simple_0, rs_simple_1, rs_simple_0_entry_num,
                             rs_simple_1_entry_num, selector, dispatch_ready,
                             x.e0, x.e1, x.n0, x.n1, x.sel, x.rdy);
                end
            end
        end
    end

    task automatic idle();
        rst = 0; flush = 0; dispatch_valid = 0; dispatch_inst = '0; dispatch_rob_num = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_data = '0; simple_0_issue = 0; simple_1_issue = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    task automatic disp(input logic [113:0] inst, input logic [3:0] rob);
        dispatch_valid = 1; dispatch_inst = inst; dispatch_rob_num = rob;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
        cdb_valid = 1; cdb_tag = tag; cdb_data = data;
    endtask

    initial begin : stim
        logic [113:0] a, aw, b, c, d, e, f, g, gw, h, hw;
        a  = mk(6'd1, 32'd3, 1'b0, 32'd5, 1'b1, 5'd2);
        aw = mk(6'd1, 32'hDEADBEEF, 1'b1, 32'd5, 1'b1, 5'd2);
        b  = mk(6'd2, 32'd11, 1'b1, 32'd10, 1'b1, 5'd3);
        c  = mk(6'd3, 32'd21, 1'b1, 32'd20, 1'b1, 5'd4);
        d  = mk(6'd4, 32'd31, 1'b1, 32'd30, 1'b1, 5'd5);
        e  = mk(6'd5, 32'd41, 1'b1, 32'd40, 1'b1, 5'd6);
        f  = mk(6'd6, 32'd51, 1'b1, 32'd50, 1'b1, 5'd7);
        g  = mk(6'd7, 32'h55, 1'b1, 32'd9, 1'b0, 5'd8);
        gw = mk(6'd7, 32'h55, 1'b1, 32'h1234, 1'b1, 5'd8);
        h  = mk(6'd8, 32'd2, 1'b0, 32'd2, 1'b0, 5'd9);
        hw = mk(6'd8, 32'hAB, 1'b1, 32'hAB, 1'b1, 5'd9);

        idle();
        tick(); rst = 1;
        tick(); rst = 1;
        expect_st("reset", '0, '0, 4'd0, 4'd0, 1'b0, 1'b1);

        tick(); disp(a, 4'd7);
        expect_st("dispatch_a", a, '0, 4'd7, 4'd0, 1'b0, 1'b1);
        tick(); cdb(4'd3, 32'hDEADBEEF);
        expect_st("wake_s2", aw, '0, 4'd7, 4'd0, 1'b0, 1'b1);

        tick(); flush = 1;
        expect_st("flush_one", '0, '0, 4'd0, 4'd0, 1'b0, 1'b1);
        tick(); disp(b, 4'd1);
        expect_st("dispatch_b", b, '0, 4'd1, 4'd0, 1'b0, 1'b1);
        tick(); disp(c, 4'd2);
        expect_st("dispatch_c_full", b, c, 4'd1, 4'd2, 1'b1, 1'b0);
        tick(); disp(d, 4'd3);
        expect_st("full_ignored", b, c, 4'd1, 4'd2, 1'b1, 1'b0);
        tick(); simple_0_issue = 1;
        expect_st("issue0", msk(b), c, 4'd1, 4'd2, 1'b1, 1'b1);
        tick(); disp(d, 4'd3);
        expect_st("refill0", d, c, 4'd3, 4'd2, 1'b0, 1'b0);
        tick(); simple_1_issue = 1;
        expect_st("issue1", d, msk(c), 4'd3, 4'd2, 1'b0, 1'b1);
        tick(); simple_0_issue = 1; disp(e, 4'd5);
        expect_st("issue_dispatch", msk(d), e, 4'd3, 4'd5, 1'b1, 1'b1);
        tick(); disp(f, 4'd6);
        expect_st("dispatch_f", f, e, 4'd6, 4'd5, 1'b0, 1'b0);
        tick(); simple_0_issue = 1; simple_1_issue = 1;
        expect_st("issue_both", msk(f), msk(e), 4'd6, 4'd5, 1'b0, 1'b1);
        tick(); simple_0_issue = 1; simple_1_issue = 1; cdb(4'd6, 32'h77);
        expect_st("issue_empty", msk(f), msk(e), 4'd6, 4'd5, 1'b0, 1'b1);

        tick(); disp(g, 4'd4); cdb(4'd9, 32'h1234);
        expect_st("dispatch_capture", gw, msk(e), 4'd4, 4'd5, 1'b0, 1'b1);
        tick(); disp(h, 4'd8);
        expect_st("dispatch_h", gw, h, 4'd4, 4'd8, 1'b1, 1'b0);
        tick(); cdb(4'd6, 32'hFF);
        expect_st("tag_miss", gw, h, 4'd4, 4'd8, 1'b1, 1'b0);
        tick(); cdb(4'd2, 32'hAB);
        expect_st("wake_both_src", gw, hw, 4'd4, 4'd8, 1'b1, 1'b0);
        tick(); flush = 1; disp(a, 4'd7); cdb(4'd3, 32'h99); simple_0_issue = 1;
        expect_st("flush_priority", '0, '0, 4'd0, 4'd0, 1'b0, 1'b1);

`ifdef RS_SIMPLE_PERF_EN
        tick(); rst = 1;
        expect_perf("perf_reset", 32'd0, 32'd0);
        tick(); disp(b, 4'd1);
        tick(); disp(c, 4'd2);
        tick(); disp(d, 4'd3);
        tick(); disp(d, 4'd3);
        tick(); disp(d, 4'd3);
        tick(); simple_0_issue = 1; simple_1_issue = 1;
        expect_perf("perf_counts", 32'd2, 32'd3);
        tick(); flush = 1;
        expect_perf("perf_survive_flush", 32'd2, 32'd3);
`endif

        tick();
        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending expectations, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: simulation still running, required finish");
        $fatal(1);
    end

endmodule
